// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: round-robin burst arbiter on the async FIFO read side; RD_ARB_TIMEOUT_EN adds stall timeout release
module rd_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rinc,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rdy,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rvalid,
  output logic [DATA_SIZE-1:0] rdata_out,
  output logic                 busy
`ifdef RD_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_evt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] BL = 8'(BURST_LEN);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0] g_q, g_d, rr_ptr_q, rr_ptr_d, sel, nxt;
  logic [7:0] cnt_q, cnt_d;
  logic found, pop, rel, to_hit;
`ifdef RD_ARB_TIMEOUT_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] stall_q, stall_d;
  logic timeout_evt_q, timeout_evt_d;
  assign to_hit = (state_q == GRANT) & ~pop & req[g_q] & (stall_q + 8'd1 == TO);
  assign timeout_evt = timeout_evt_q;
`else
  assign to_hit = 1'b0;
`endif
  assign pop = rrst & (state_q == GRANT) & req[g_q] & rdy[g_q] & ~rEmpty;
  assign rel = (state_q == GRANT) & (~req[g_q] | (pop & (cnt_q + 8'd1 == BL)) | to_hit);
  assign nxt = IW'((int'(g_q) + 1) % NUM_REQ);
  assign rinc = pop;
  assign rvalid = pop ? gnt_q : '0;
  assign rdata_out = pop ? rdata : '0;
  assign gnt = gnt_q;
  assign busy = (state_q == GRANT);
  // first requester at or above rr_ptr, wrapping; lowest offset wins
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[IW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        sel = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  // next grant, pointer and burst count
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    g_d = g_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = pop ? cnt_q + 8'd1 : cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
        g_d = sel;
        cnt_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      gnt_d = '0;
      rr_ptr_d = nxt;
    end
  end
`ifdef RD_ARB_TIMEOUT_EN
  // stall count runs only while the grantee wants data but cannot get it
  always_comb begin
    stall_d = (state_q == IDLE | pop | rel) ? 8'd0 : req[g_q] ? stall_q + 8'd1 : stall_q;
    timeout_evt_d = to_hit;
  end
`endif
  // state registers with synchronous active-low reset
  always_ff @(posedge rclk) begin
    if (!rrst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      g_q <= '0;
      rr_ptr_q <= '0;
      cnt_q <= '0;
`ifdef RD_ARB_TIMEOUT_EN
      stall_q <= '0;
      timeout_evt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      g_q <= g_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
`ifdef RD_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      timeout_evt_q <= timeout_evt_d;
`endif
    end
  end
endmodule

// File: tb/tb_rd_port_arbiter.sv
// tb_rd_port_arbiter: directed checks of burst, round-robin, stall, early release, reset and timeout
module tb_rd_port_arbiter;
  logic rclk = 1'b0, rrst, rEmpty, rinc, busy;
  logic [7:0] rdata, rdata_out;
  logic [3:0] req, rdy, gnt, rvalid;
  logic [7:0] fifo [256];
  int head, fifo_n, exp_head, checks, errors;
  logic force_empty;
  logic s_rinc, s_busy, s_tevt;
  logic [3:0] s_gnt, s_rvalid;
  logic [7:0] s_rdout;
`ifdef RD_ARB_TIMEOUT_EN
  logic timeout_evt;
`endif
  always #5 rclk = ~rclk;
  assign rEmpty = (head >= fifo_n) | force_empty;
  assign rdata = fifo[8'(head)];
  rd_port_arbiter dut (
    .rclk(rclk), .rrst(rrst), .rEmpty(rEmpty), .rdata(rdata), .rinc(rinc),
    .req(req), .rdy(rdy), .gnt(gnt), .rvalid(rvalid), .rdata_out(rdata_out), .busy(busy)
`ifdef RD_ARB_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    #3;
    s_gnt = gnt;
    s_rinc = rinc;
    s_rvalid = rvalid;
    s_rdout = rdata_out;
    s_busy = busy;
`ifdef RD_ARB_TIMEOUT_EN
    s_tevt = timeout_evt;
`else
    s_tevt = 1'b0;
`endif
    @(posedge rclk);
    #1;
    if (s_rinc) head++;
  endtask
  task automatic exp_cycle(input logic [3:0] g, input logic p);
    tick();
    chk("gnt", 32'(s_gnt), 32'(g));
    chk("rinc", 32'(s_rinc), 32'(p));
    chk("rvalid", 32'(s_rvalid), p ? 32'(g) : 32'd0);
    chk("rdata_out", 32'(s_rdout), p ? 32'(fifo[8'(exp_head)]) : 32'd0);
    chk("busy", 32'(s_busy), 32'(g != 4'd0));
    if (p) exp_head++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) fifo[i] = 8'(i * 37 + 5);
    head = 0;
    exp_head = 0;
    fifo_n = 200;
    force_empty = 1'b0;
    rrst = 1'b0;
    req = 4'b1111;
    rdy = 4'b1111;
    @(posedge rclk);
    #1;
    for (int i = 0; i < 3; i++) exp_cycle(4'b0000, 1'b0);
    rrst = 1'b1;
    exp_cycle(4'b0000, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 16; w++) exp_cycle(4'(1 << (b % 4)), 1'b1);
      if (b == 4) req = 4'b0000;
      exp_cycle(4'b0000, 1'b0);
    end
    chk("fair_pops", 32'(head), 32'(exp_head));
    rrst = 1'b0;
    exp_cycle(4'b0000, 1'b0);
    rrst = 1'b1;
    head = 0;
    exp_head = 0;
    fifo_n = 20;
    req = 4'b0001;
    exp_cycle(4'b0000, 1'b0);
    for (int w = 0; w < 16; w++) exp_cycle(4'b0001, 1'b1);
    exp_cycle(4'b0000, 1'b0);
    for (int w = 0; w < 4; w++) exp_cycle(4'b0001, 1'b1);
    exp_cycle(4'b0001, 1'b0);
    req = 4'b0000;
    exp_cycle(4'b0001, 1'b0);
    fifo_n = 200;
    req = 4'b0100;
    exp_cycle(4'b0000, 1'b0);
    begin
      int pops;
      logic p;
      pops = 0;
      for (int c = 0; c < 100 && pops < 16; c++) begin
        force_empty = ~c[0];
        rdy = (c >= 3 && c <= 5) ? 4'b1011 : 4'b1111;
        p = ~force_empty & rdy[2];
        exp_cycle(4'b0100, p);
        if (p) pops++;
      end
    end
    force_empty = 1'b0;
    rdy = 4'b1111;
    req = 4'b0010;
    exp_cycle(4'b0000, 1'b0);
    chk("stall_pops", 32'(head), 32'(exp_head));
    for (int w = 0; w < 5; w++) exp_cycle(4'b0010, 1'b1);
    req = 4'b0000;
    exp_cycle(4'b0010, 1'b0);
    req = 4'b1111;
    exp_cycle(4'b0000, 1'b0);
    for (int w = 0; w < 3; w++) exp_cycle(4'b0100, 1'b1);
    rrst = 1'b0;
    exp_cycle(4'b0100, 1'b0);
    rrst = 1'b1;
    exp_cycle(4'b0000, 1'b0);
    chk("reset_pops", 32'(head), 32'(exp_head));
    exp_cycle(4'b0001, 1'b1);
    req = 4'b0000;
    exp_cycle(4'b0001, 1'b0);
    exp_cycle(4'b0000, 1'b0);
    rrst = 1'b0;
    exp_cycle(4'b0000, 1'b0);
    rrst = 1'b1;
    req = 4'b0011;
    force_empty = 1'b1;
    exp_cycle(4'b0000, 1'b0);
`ifdef RD_ARB_TIMEOUT_EN
    for (int s = 0; s < 32; s++) begin
      exp_cycle(4'b0001, 1'b0);
      chk("tevt_low", 32'(s_tevt), 32'd0);
    end
    exp_cycle(4'b0000, 1'b0);
    chk("tevt_pulse", 32'(s_tevt), 32'd1);
    force_empty = 1'b0;
    exp_cycle(4'b0010, 1'b1);
    chk("tevt_clear", 32'(s_tevt), 32'd0);
    req = 4'b0000;
    exp_cycle(4'b0010, 1'b0);
`else
    for (int s = 0; s < 40; s++) exp_cycle(4'b0001, 1'b0);
    force_empty = 1'b0;
    exp_cycle(4'b0001, 1'b1);
    req = 4'b0000;
    exp_cycle(4'b0001, 1'b0);
`endif
    exp_cycle(4'b0000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
- Round-robin arbiter that shares the read side of the async FIFO (rclk domain) between NUM_REQ consumers.
- Grants one consumer at a time for a burst of up to BURST_LEN words.
- Drives the FIFO read-increment strobe and steers the head-of-FIFO data to the granted consumer with a per-requester valid.
- Sits between the FIFO read-pointer/empty logic and the downstream consumers.

Parameters:
- NUM_REQ, 4: number of consumers; must be 2 to 8.
- DATA_SIZE, 8: FIFO data width.
- BURST_LEN, 16: maximum words popped per grant; must be 1 to 255.
- TIMEOUT, 32: stall cycles before forced release. Used only with RD_ARB_TIMEOUT_EN; must be 1 to 255.

Ports:
- rclk, input, 1: read-domain clock.
- rrst, input, 1: synchronous active-low reset, sampled on rising rclk.
- rEmpty, input, 1: FIFO empty flag, registered in the FIFO.
- rdata, input, DATA_SIZE: FIFO head word, valid whenever rEmpty=0.
- rinc, output, 1: FIFO pop strobe.
- req, input, NUM_REQ: per-consumer request, level.
- rdy, input, NUM_REQ: per-consumer can-accept-word.
- gnt, output, NUM_REQ: one-hot registered grant.
- rvalid, output, NUM_REQ: word transferred to consumer i this cycle.
- rdata_out, output, DATA_SIZE: shared data bus to consumers.
- busy, output, 1: high while in GRANT state.

Behaviour:
- Reset: one clock, synchronous active-low reset. When rrst=0 at a rising rclk:
  - state=IDLE, gnt=0, rr_ptr=0, burst count=0, stall count=0.
  - rinc=0, rvalid=0, busy=0, rdata_out=0.
- Reset mid-burst aborts the burst and pops nothing on the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0, select the first requester i with req[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - Next cycle: gnt=one-hot(i), state=GRANT, burst count=0.
  - If req=0, stay in IDLE.
- GRANT, granted index g:
  - Pop condition: pop = req[g] & rdy[g] & ~rEmpty.
  - rinc=pop, rvalid[g]=pop, and all other rvalid bits=0. These are combinational from registered gnt and the inputs.
  - rdata_out=rdata when pop=1, else 0.
  - Each pop increments the burst count.
- Exit from GRANT to IDLE on the rising edge when either:
  - the burst count reaches BURST_LEN (the pop that makes count==BURST_LEN counts), or
  - req[g]=0 in that cycle (no pop occurs in that cycle).
- On exit: gnt=0, rr_ptr=(g+1) mod NUM_REQ. IDLE always lasts exactly one cycle before the next grant.
- rEmpty=1 or rdy[g]=0 stalls the transfer: no pop, grant held, count unchanged.
- Latency:
  - req rise in IDLE to gnt: 1 cycle.
  - gnt to first possible pop: 0 cycles.
  - Minimum gap between bursts of different requesters: 1 idle cycle.
- The FIFO updates rEmpty on the edge after the last pop, so rinc is never asserted while rEmpty=1.
- rinc is asserted in at most one cycle per word; the pop count over a burst equals the sum of rvalid pulses.
- Requests from non-granted consumers are ignored until the next IDLE.
- rr_ptr advances only on grant release, never in IDLE without a grant.
- gnt is always one-hot or zero.
- Counter widths: 8 bits. No wrap is possible given the parameter limits.

Optional Feature:
- Macro: RD_ARB_TIMEOUT_EN.
- With the macro defined:
  - A stall counter in GRANT increments on each cycle with pop=0 and req[g]=1, and clears on pop.
  - When it reaches TIMEOUT, the grant is released exactly as for a burst-complete exit: rr_ptr=g+1, next state IDLE.
  - Output timeout_evt, 1 bit, pulses high for 1 cycle on that release edge; reset value 0.
- Without the macro: no stall counter and no timeout_evt port. The grant is held indefinitely while req[g]=1 and the burst is incomplete.

Test Plan:
- Reset: hold rrst=0 for 3 cycles with req=4'b1111 and rEmpty=0 -> gnt=0, rinc=0, rvalid=0, busy=0 throughout. First gnt=4'b0001 one cycle after rrst=1.
- Full burst: BURST_LEN=16, req=4'b0001, rdy=1, FIFO preloaded with 20 words -> exactly 16 rinc pulses on consecutive cycles with rdata_out matching FIFO order. gnt drops after the 16th pop, re-grants 0001 after 1 IDLE cycle, and the remaining 4 words follow.
- Round-robin fairness: req=4'b1111, FIFO continuously non-empty -> grant order 0,1,2,3,0 with 16 pops each and one idle cycle between bursts.
- Stalls: grant to requester 2, rEmpty toggles 1/0 every cycle, rdy[2] low for cycles 3-5 -> rinc only when rEmpty=0 and rdy[2]=1. Grant held until 16 pops; no pop while rEmpty=1.
- Early release and reset mid-burst: requester 1 drops req after 5 pops -> gnt released next edge, rr_ptr=2, no 6th pop. Then a new burst is started and rrst=0 is asserted after 3 pops -> next cycle state IDLE, rr_ptr=0, and the FIFO sees exactly 3 pops.
- Timeout (RD_ARB_TIMEOUT_EN, TIMEOUT=32): grant to requester 0 with rEmpty=1 held -> timeout_evt pulses at stall cycle 32, gnt released, and requester 1 (req=4'b0011) is granted after 1 idle cycle.
